// File: rtl/overlay_sched_pkg.sv
// overlay_pkg: shared state encoding and width helpers for the overlay scheduler.
package overlay_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    function automatic int id_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic int cnt_w(int d);
        return $clog2(d + 1);
    endfunction
endpackage

// File: rtl/overlay_sched_if.sv
// overlay_sched_if: requester and response bundle between requesters and the scheduler.
interface overlay_sched_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ*DATA_W-1:0] req_data_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic [N_REQ-1:0]        rsp_valid_o;
    logic [DATA_W-1:0]       rsp_data_o;
    logic [N_REQ-1:0]        rsp_ready_i;
    modport master (output req_valid_i, req_data_i, rsp_ready_i, input req_ready_o, rsp_valid_o, rsp_data_o);
    modport slave  (input req_valid_i, req_data_i, rsp_ready_i, output req_ready_o, rsp_valid_o, rsp_data_o);
endinterface

// File: rtl/overlay_sched_rr_arbiter.sv
// rr_arbiter: round-robin one-hot pick starting at ptr, ptr advances past each accepted grant.
module rr_arbiter import overlay_pkg::*; #(
    parameter int N = 4,
    localparam int IW = id_w(N)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);
    logic [IW-1:0] ptr, nxt, j;
    // scan downward so the candidate closest to ptr is the last one written
    always_comb begin
        gnt = '0;
        nxt = ptr;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) begin
                gnt = '0;
                gnt[j] = 1'b1;
                nxt = IW'((int'(ptr) + k + 1) % N);
            end
        end
        if (!en) gnt = '0;
    end
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) ptr <= '0;
        else if (en && |req) ptr <= nxt;
endmodule

// File: rtl/overlay_sched.sv
// overlay_sched: shares one DEPTH-stage delay line among N_REQ requesters,
// returning each tagged word on its owner's response port.
module overlay_sched import overlay_pkg::*; #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    localparam int ID_W  = id_w(N_REQ),
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    overlay_sched_if.slave   bus,
    output logic             busy_o,
    output logic [CNT_W-1:0] count_o
);
    state_t st;
    logic adv, gok, acc;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0] gid;
    logic [DATA_W-1:0] gdat;
    logic [DEPTH-1:0] vld, vnx;
    logic [ID_W-1:0] ids [DEPTH];
    logic [DATA_W-1:0] dats [DEPTH];
    logic [CNT_W-1:0] cnt_nxt;

    assign adv = !vld[DEPTH-1] || bus.rsp_ready_i[ids[DEPTH-1]];
    assign gok = en_i && adv && st != DRAIN;
    assign acc = |gnt;
    assign bus.req_ready_o = gnt;
    assign bus.rsp_valid_o = vld[DEPTH-1] ? N_REQ'(1) << ids[DEPTH-1] : '0;
    assign bus.rsp_data_o = dats[DEPTH-1];
    assign cnt_nxt = CNT_W'($countones(vnx));

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .req   (bus.req_valid_i),
        .en    (gok),
        .gnt   (gnt)
    );

    always_comb begin
        gid = '0;
        gdat = '0;
        for (int i = 0; i < N_REQ; i++)
            if (gnt[i]) begin
                gid = ID_W'(i);
                gdat = bus.req_data_i[i*DATA_W +: DATA_W];
            end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stg
        logic v_q, v_in;
        logic [ID_W-1:0] id_q, id_in;
        logic [DATA_W-1:0] dat_q, dat_in;
        if (k == 0) begin : g_head
            assign {v_in, id_in, dat_in} = {acc, gid, gdat};
        end else begin : g_body
            assign {v_in, id_in, dat_in} = {vld[k-1], ids[k-1], dats[k-1]};
        end
        assign vnx[k] = adv ? v_in : v_q;
        always_ff @(posedge clk_i or negedge rst_ni)
            if (!rst_ni) {v_q, id_q, dat_q} <= '0;
            else if (adv) {v_q, id_q, dat_q} <= {v_in, id_in, dat_in};
        assign {vld[k], ids[k], dats[k]} = {v_q, id_q, dat_q};
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            st <= IDLE;
            count_o <= '0;
            busy_o <= 1'b0;
        end else begin
            count_o <= cnt_nxt;
            busy_o <= |vnx;
            unique case (st)
                IDLE:    if (acc) st <= RUN;
                RUN:     if (!en_i) st <= DRAIN;
                         else if (cnt_nxt == '0 && !acc) st <= IDLE;
                DRAIN:   if (cnt_nxt == '0) st <= IDLE;
                default: st <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_overlay_sched.sv
// tb_overlay_sched: directed and random stimulus checked every cycle against a slot-level model.
module tb_overlay_sched;
    localparam int N = 4;
    localparam int D = 2;

    logic clk_i, rst_ni, en_i, busy_o;
    logic [1:0] count_o;
    overlay_sched_if #(.N_REQ(N), .DATA_W(8)) bus ();

    overlay_sched #(.N_REQ(N), .DATA_W(8), .DEPTH(D)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .bus    (bus),
        .busy_o (busy_o),
        .count_o(count_o)
    );

    initial begin
        clk_i = 0;
        forever #5 clk_i = ~clk_i;
    end

    int ntot = 0, npass = 0;
    int dv [N];
    int mv [D], mid [D], md [D];
    int st, ptr;
    int log_q [$];

    task automatic chk(string n, int act, int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    endtask

    task automatic apply();
        bus.req_data_i = {8'(dv[3]), 8'(dv[2]), 8'(dv[1]), 8'(dv[0])};
    endtask

    task automatic model_reset();
        st = 0;
        ptr = 0;
        for (int k = 0; k < D; k++) begin
            mv[k] = 0; mid[k] = 0; md[k] = 0;
        end
    endtask

    task automatic pick(output int g, output bit a);
        a = mv[D-1] == 0 || ((int'(bus.rsp_ready_i) >> mid[D-1]) & 1) == 1;
        g = -1;
        if (en_i && a && st != 2)
            for (int k = 0; k < N; k++) begin
                int x = (ptr + k) % N;
                if (g < 0 && ((int'(bus.req_valid_i) >> x) & 1) == 1) g = x;
            end
    endtask

    task automatic do_reset();
        rst_ni = 0;
        #1;
        chk("rst_rsp_valid", int'(bus.rsp_valid_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_count", int'(count_o), 0);
        chk("rst_rsp_data", int'(bus.rsp_data_o), 0);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1;
    endtask

    // compare at the negedge, then advance the model on the following rising edge
    task automatic cycle();
        int g, cnt;
        bit a;
        @(negedge clk_i);
        pick(g, a);
        cnt = 0;
        for (int k = 0; k < D; k++) cnt += mv[k];
        chk("req_ready", int'(bus.req_ready_o), g >= 0 ? 1 << g : 0);
        chk("rsp_valid", int'(bus.rsp_valid_o), mv[D-1] != 0 ? 1 << mid[D-1] : 0);
        chk("count", int'(count_o), cnt);
        chk("busy", int'(busy_o), cnt != 0 ? 1 : 0);
        if (mv[D-1] != 0) begin
            chk("rsp_data", int'(bus.rsp_data_o), md[D-1]);
            if (a) log_q.push_back(md[D-1]);
        end
        @(posedge clk_i);
        if (a) begin
            for (int k = D - 1; k > 0; k--) begin
                mv[k] = mv[k-1]; mid[k] = mid[k-1]; md[k] = md[k-1];
            end
            mv[0] = g >= 0 ? 1 : 0;
            mid[0] = g >= 0 ? g : 0;
            md[0] = 0;
            for (int i = 0; i < N; i++) if (i == g) md[0] = dv[i];
        end
        if (g >= 0) ptr = (g + 1) % N;
        cnt = 0;
        for (int k = 0; k < D; k++) cnt += mv[k];
        case (st)
            0: if (g >= 0) st = 1;
            1: if (!en_i) st = 2; else if (cnt == 0 && g < 0) st = 0;
            default: if (cnt == 0) st = 0;
        endcase
        #1;
    endtask

    initial begin
        rst_ni = 0;
        en_i = 1;
        bus.req_valid_i = '0;
        bus.rsp_ready_i = '1;
        for (int i = 0; i < N; i++) dv[i] = 0;
        apply();
        do_reset();

        // single word from port 0
        bus.req_valid_i = 4'b0001;
        dv[0] = 'hA5;
        apply();
        #1 chk("t1_ready", int'(bus.req_ready_o), 1);
        cycle();
        bus.req_valid_i = '0;
        cycle();
        chk("t1_rsp_valid", int'(bus.rsp_valid_o), 1);
        chk("t1_rsp_data", int'(bus.rsp_data_o), 'hA5);
        repeat (3) cycle();

        // all four requesters, round-robin order
        do_reset();
        for (int i = 0; i < N; i++) dv[i] = 'h10 + i;
        apply();
        bus.req_valid_i = '1;
        log_q.delete();
        repeat (8) cycle();
        chk("t2_log_size_ok", log_q.size() >= 4 ? 1 : 0, 1);
        for (int i = 0; i < 4; i++) chk("t2_order", i < log_q.size() ? log_q[i] : -1, 'h10 + i);

        // port 2 output stalled
        do_reset();
        bus.rsp_ready_i = 4'b1011;
        repeat (8) cycle();
        chk("t3_count", int'(count_o), 2);
        chk("t3_rsp_valid", int'(bus.rsp_valid_o), 4'b0100);
        chk("t3_rsp_data", int'(bus.rsp_data_o), 'h12);
        chk("t3_ready", int'(bus.req_ready_o), 0);
        bus.rsp_ready_i = '1;
        repeat (4) cycle();

        // drain with en_i low
        chk("t4_full", int'(count_o), 2);
        en_i = 0;
        repeat (2) cycle();
        chk("t4_busy", int'(busy_o), 0);
        chk("t4_count", int'(count_o), 0);
        en_i = 1;
        #1 chk("t4_regrant", int'(|bus.req_ready_o), 1);
        repeat (4) cycle();

        // reset mid-stream
        chk("t5_full", int'(count_o), 2);
        do_reset();
        #1 chk("t5_first_gnt", int'(bus.req_ready_o), 1);
        repeat (3) cycle();

        // single requester on port 3
        do_reset();
        bus.req_valid_i = 4'b1000;
        log_q.delete();
        for (int k = 0; k < 6; k++) begin
            dv[3] = 'h30 + k;
            apply();
            cycle();
        end
        bus.req_valid_i = '0;
        repeat (3) cycle();
        chk("t6_log_size", log_q.size(), 6);
        for (int k = 0; k < 6; k++) chk("t6_order", k < log_q.size() ? log_q[k] : -1, 'h30 + k);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            bus.req_valid_i = 4'($urandom);
            bus.rsp_ready_i = 4'($urandom | $urandom);
            en_i = ($urandom % 16) != 0;
            for (int i = 0; i < N; i++) dv[i] = int'($urandom % 256);
            apply();
            if ($urandom % 500 == 0) do_reset();
            else cycle();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
